// File: rtl/onehot_encoder.sv
// rtl/onehot_encoder.sv - registered one-hot to binary encoder with zero/multi-hot flags
module onehot_encoder #(
    parameter  int BIT_WIDTH = 8,
    localparam int OUT_WIDTH = $clog2(BIT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_valid,
    output logic                 err_zero,
    output logic                 err_multi
);

    logic [BIT_WIDTH-1:0] lowest;
    logic [OUT_WIDTH-1:0] enc;
    logic                 is_zero;
    logic                 is_multi;

    // Isolate the lowest set bit first, so the OR-reduction below only ever
    // sees one hot line and can never form a code above BIT_WIDTH-1.
    always_comb begin
        lowest   = in & (~in + BIT_WIDTH'(1));
        enc      = '0;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            if (lowest[i]) begin
                enc = enc | OUT_WIDTH'(i);
            end
        end
        is_zero  = ~|in;
        is_multi = |(in & (in - BIT_WIDTH'(1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            err_zero  <= 1'b0;
            err_multi <= 1'b0;
        end else begin
            out_valid <= in_valid;
            err_zero  <= in_valid & is_zero;
            err_multi <= in_valid & is_multi;
            if (in_valid) begin
                out <= enc;
            end
        end
    end

endmodule

// File: tb/tb_onehot_encoder.sv
// tb/tb_onehot_encoder.sv - scoreboard bench for 8-wide and 5-wide onehot_encoder
module tb_onehot_encoder;

    typedef struct packed {
        logic       valid;
        logic [2:0] out;
        logic       ez;
        logic       em;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       v8, v5;
    logic [7:0] i8;
    logic [4:0] i5;
    logic [2:0] o8, o5;
    logic       ov8, ov5, ez8, ez5, em8, em5;

    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q5[$];
    logic [2:0] last8 = '0;
    logic [2:0] last5 = '0;

    always #5 clk = ~clk;

    onehot_encoder #(.BIT_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in(i8),
        .out(o8), .out_valid(ov8), .err_zero(ez8), .err_multi(em8)
    );

    onehot_encoder #(.BIT_WIDTH(5)) dut5 (
        .clk(clk), .reset(reset), .in_valid(v5), .in(i5),
        .out(o5), .out_valid(ov5), .err_zero(ez5), .err_multi(em5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic rst, input logic v, input logic [7:0] vec,
                                   input int w, inout logic [2:0] last);
        exp_t r;
        int   n;
        r = '0;
        if (rst) begin
            last = '0;
        end else if (v) begin
            n       = $countones(vec);
            r.valid = 1'b1;
            r.ez    = (n == 0);
            r.em    = (n > 1);
            last    = '0;
            for (int i = w - 1; i >= 0; i--) begin
                if (vec[i]) last = 3'(i);
            end
        end
        r.out = last;
        return r;
    endfunction

    task automatic drive(input logic rst, input logic a8, input logic [7:0] d8,
                         input logic a5, input logic [4:0] d5);
        reset = rst;
        v8    = a8;
        i8    = d8;
        v5    = a5;
        i5    = d5;
        q8.push_back(model(rst, a8, d8, 8, last8));
        q5.push_back(model(rst, a5, {3'b000, d5}, 5, last5));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t r;
        if (q8.size() > 0) begin
            r = q8.pop_front();
            check("w8_out_valid", 32'(ov8), 32'(r.valid));
            check("w8_out",       32'(o8),  32'(r.out));
            check("w8_err_zero",  32'(ez8), 32'(r.ez));
            check("w8_err_multi", 32'(em8), 32'(r.em));
        end
        if (q5.size() > 0) begin
            r = q5.pop_front();
            check("w5_out_valid", 32'(ov5), 32'(r.valid));
            check("w5_out",       32'(o5),  32'(r.out));
            check("w5_err_zero",  32'(ez5), 32'(r.ez));
            check("w5_err_multi", 32'(em5), 32'(r.em));
        end
    end

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0, 5'h00);
        drive(1'b1, 1'b1, 8'hff, 1'b1, 5'h1f);

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h01 << i, 1'b1, 5'h01 << (i % 5));
        end

        drive(1'b0, 1'b1, 8'b00000000, 1'b1, 5'b00000);
        drive(1'b0, 1'b1, 8'b00101000, 1'b1, 5'b00011);
        drive(1'b0, 1'b1, 8'b11111111, 1'b1, 5'b10000);
        drive(1'b0, 1'b1, 8'b10000000, 1'b1, 5'b11000);

        drive(1'b0, 1'b1, 8'b01000000, 1'b1, 5'b01000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'b00000001, 1'b0, 5'b00001);
        end

        drive(1'b1, 1'b1, 8'b00010000, 1'b1, 5'b00100);
        drive(1'b0, 1'b1, 8'b00010000, 1'b1, 5'b00100);

        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 5'($urandom));
        end

        drive(1'b0, 1'b0, 8'h00, 1'b0, 5'h00);
        @(negedge clk);
        #1;
        check("w8_queue_drained", 32'(q8.size()), 32'd0);
        check("w5_queue_drained", 32'(q5.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_encoder.md
Name:
onehot_encoder

Overview:
- Clocked one-hot to binary encoder used in the OoO core's select and wakeup paths.
- Converts a BIT_WIDTH-wide one-hot vector into its binary index.
- Output is registered, so latency is one cycle.
- Flags illegal inputs: all-zero and multi-hot. A multi-hot input resolves to the lowest set bit.

Parameters:
- BIT_WIDTH, default 8: number of one-hot input lines. Must be 2 or more; non-power-of-2 values are legal.
- OUT_WIDTH, derived localparam = $clog2(BIT_WIDTH): width of the binary output. It is not overridable.

Ports:
- clk, input, 1: rising-edge clock for all state.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: qualifies `in` for the current cycle.
- in, input, BIT_WIDTH: one-hot request vector; bit i means index i.
- out, output, OUT_WIDTH: registered binary index of the encoded input.
- out_valid, output, 1: registered; high the cycle after an accepted `in_valid`.
- err_zero, output, 1: registered; the accepted input had no bits set.
- err_multi, output, 1: registered; the accepted input had two or more bits set.

Behaviour:
- Clocking and reset:
  - All outputs are flops clocked on the rising edge of clk.
  - `reset` is sampled synchronously. While high at an edge: out=0, out_valid=0, err_zero=0, err_multi=0.
  - `reset` overrides `in_valid` in the same cycle. Reset mid-stream discards the in-flight encode; there is no output for the input presented in the reset cycle.
- Latency: input sampled at edge N appears on the outputs after edge N and holds until edge N+1. There is no combinational path from input to output.
- Accepted cycle (in_valid=1, reset=0):
  - out_valid <= 1.
  - Exactly one bit i set: out <= i, err_zero <= 0, err_multi <= 0.
  - No bits set: out <= 0, err_zero <= 1, err_multi <= 0.
  - Two or more bits set: out <= index of the lowest set bit, err_zero <= 0, err_multi <= 1.
- Idle cycle (in_valid=0, reset=0):
  - out_valid <= 0, err_zero <= 0, err_multi <= 0.
  - out holds its previous value.
- Error flags are only meaningful when out_valid=1. They never assert together.
- Back-to-back: a new input may be accepted every cycle. There is no backpressure and no ready signal.
- Non-power-of-2 BIT_WIDTH: out never exceeds BIT_WIDTH-1. Unused high codes are never produced.
- Encoding structure:
  - Lowest-index priority encode, e.g. an OR-reduction per output bit combined with a lowest-set-bit mask.
  - Multi-hot detection is `(in & (in - 1)) != 0`, or an equivalent popcount > 1 check.
- `in` contents are ignored entirely when in_valid=0.

Test Plan:
- Reset, then sweep in_valid=1 with in = 8'b00000001, 8'b00000010, … 8'b10000000, one per cycle -> out = 0,1,2,…,7 each one cycle later; out_valid=1, err_zero=0, err_multi=0 throughout.
- Accept in=8'b00000000 -> next cycle out=0, out_valid=1, err_zero=1, err_multi=0.
- Accept in=8'b00101000 -> next cycle out=3, err_multi=1, err_zero=0. Accept in=8'b11111111 -> out=0, err_multi=1.
- Accept in=8'b01000000 (out=6), then hold in_valid=0 with in=8'b00000001 for 3 cycles -> out stays 6, out_valid=0, both error flags 0.
- Reset mid-stream: in_valid=1, in=8'b00010000 with reset=1 on the same edge -> out=0, out_valid=0. The next accepted in=8'b00010000 gives out=4.
- BIT_WIDTH=5 instance (OUT_WIDTH=3): in=5'b10000 -> out=3'd4; in=5'b00011 -> out=0, err_multi=1.
